stack_arbiter: RTL and testbench

Shares one 4-entry, 4-bit LIFO stack between two requesters, A and B. The block runs a request/acknowledge handshake per requester and arbitrates round-robin. It issues single-cycle push/pop strobes to the stack and returns popped data. It keeps a shadow occupancy count, so that overflow and underflow are rejected with an error response rather than being silently dropped.

---
 rtl/stack_arbiter.sv | 76 +++++++
 tb/tb_stack_arbiter.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/stack_arbiter.sv
// stack_arbiter: round-robin two-requester front end for a shared LIFO,
// rejecting overflow/underflow against a shadow occupancy count.
module stack_arbiter #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_req,
  input  logic             a_op,
  input  logic [WIDTH-1:0] a_din,
  output logic             a_ack,
  input  logic             b_req,
  input  logic             b_op,
  input  logic [WIDTH-1:0] b_din,
  output logic             b_ack,
  output logic             err,
  output logic [WIDTH-1:0] rd_data,
  output logic             stk_push,
  output logic             stk_pop,
  output logic [WIDTH-1:0] stk_din,
  input  logic [WIDTH-1:0] stk_dout,
  output logic             stk_nrst,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);
  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;
  state_t state, state_n;
  logic last, owner, op, bad;
  logic [WIDTH-1:0] din;
  logic gnt, sel, sel_op, sel_bad;
  always_comb begin
    gnt = a_req | b_req;
    sel = (a_req && b_req) ? ~last : b_req;
    sel_op = sel ? b_op : a_op;
    sel_bad = sel_op ? (count == '0) : (count == CW'(DEPTH));
    state_n = state == IDLE    ? (gnt ? (sel_bad ? RESP : ISSUE) : IDLE) :
              state == ISSUE   ? (op ? CAPTURE : RESP) :
              state == CAPTURE ? RESP : IDLE;
  end
  // last resets to B so that A wins the first contest
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      count   <= '0;
      last    <= 1'b1;
      owner   <= 1'b0;
      op      <= 1'b0;
      bad     <= 1'b0;
      din     <= '0;
      rd_data <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && gnt) begin
        owner <= sel;
        last  <= sel;
        op    <= sel_op;
        bad   <= sel_bad;
        din   <= sel ? b_din : a_din;
      end
      if (state == ISSUE) count <= op ? count - CW'(1) : count + CW'(1);
      if (state == CAPTURE) rd_data <= stk_dout;
    end
  end
  assign a_ack    = state == RESP && !owner;
  assign b_ack    = state == RESP && owner;
  assign err      = state == RESP && bad;
  assign stk_push = state == ISSUE && !op;
  assign stk_pop  = state == ISSUE && op;
  assign stk_din  = din;
  assign stk_nrst = ~rst;
  assign full     = count == CW'(DEPTH);
  assign empty    = count == '0;
endmodule

// File: tb/tb_stack_arbiter.sv
// tb_stack_arbiter: directed and random requests checked against a queue-based reference.
module tb_stack_arbiter;
  logic clk = 0, rst = 1;
  logic a_req = 0, a_op = 0, b_req = 0, b_op = 0;
  logic [3:0] a_din = 0, b_din = 0;
  logic a_ack, b_ack, err, stk_push, stk_pop, stk_nrst, full, empty;
  logic [3:0] rd_data, stk_din, stk_dout;
  logic [2:0] count;
  stack_arbiter dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_op(a_op), .a_din(a_din), .a_ack(a_ack),
    .b_req(b_req), .b_op(b_op), .b_din(b_din), .b_ack(b_ack),
    .err(err), .rd_data(rd_data),
    .stk_push(stk_push), .stk_pop(stk_pop), .stk_din(stk_din),
    .stk_dout(stk_dout), .stk_nrst(stk_nrst),
    .count(count), .full(full), .empty(empty)
  );
  always #5 clk = ~clk;
  logic [3:0] mem [4];
  int sp = 0;
  always @(posedge clk) begin
    if (!stk_nrst) begin
      sp <= 0;
      stk_dout <= '0;
    end else if (stk_push && sp < 4) begin
      mem[sp] <= stk_din;
      sp <= sp + 1;
    end else if (stk_pop && sp > 0) begin
      stk_dout <= mem[sp-1];
      sp <= sp - 1;
    end
  end
  int n_cmp = 0, n_bad = 0;
  bit last_m = 1;
  logic [3:0] rd_m = 0;
  logic [3:0] ref_q[$];
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1; a_req = 0; b_req = 0;
    @(negedge clk);
    chk("rst_nrst", stk_nrst, 0);
    chk("rst_count", count, 0);
    chk("rst_acks", {a_ack, b_ack, err}, 0);
    chk("rst_strobes", {stk_push, stk_pop}, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_stk_din", stk_din, 0);
    rst = 0;
    ref_q.delete(); last_m = 1; rd_m = 0;
  endtask
  task automatic run(input bit ra, input bit oa, input logic [3:0] da,
                     input bit rb, input bit ob, input logic [3:0] db);
    bit ord [2];
    int n;
    @(negedge clk);
    a_req = ra; a_op = oa; a_din = da;
    b_req = rb; b_op = ob; b_din = db;
    n = (ra && rb) ? 2 : 1;
    ord[0] = (ra && rb) ? !last_m : rb;
    ord[1] = !ord[0];
    for (int k = 0; k < n; k++) begin
      bit own, op, e;
      logic [3:0] d, pd;
      int lat, pushes, pops, both, early;
      own = ord[k];
      op = own ? ob : oa;
      d = own ? db : da;
      e = op ? (ref_q.size() == 0) : (ref_q.size() == 4);
      lat = (e ? 1 : op ? 3 : 2) + (k > 0 ? 1 : 0);
      if (!e && op) rd_m = ref_q.pop_back();
      else if (!e) ref_q.push_back(d);
      last_m = own;
      pushes = 0; pops = 0; both = 0; early = 0; pd = 0;
      for (int i = 1; i <= lat; i++) begin
        @(negedge clk);
        if (i < lat && (a_ack || b_ack)) early++;
        pushes += int'(stk_push);
        pops += int'(stk_pop);
        if (stk_push && stk_pop) both++;
        if (stk_push) pd = stk_din;
      end
      chk("early_ack", early, 0);
      chk("a_ack", a_ack, !own);
      chk("b_ack", b_ack, own);
      chk("err", err, e);
      chk("rd_data", rd_data, rd_m);
      chk("push_strobes", pushes, (!e && !op) ? 1 : 0);
      chk("pop_strobes", pops, (!e && op) ? 1 : 0);
      chk("strobe_overlap", both, 0);
      if (!e && !op) chk("stk_din", pd, d);
      chk("count", count, ref_q.size());
      chk("full", full, ref_q.size() == 4);
      chk("empty", empty, ref_q.size() == 0);
      if (own) b_req = 0; else a_req = 0;
    end
  endtask
  initial begin
    repeat (2) @(negedge clk);
    do_reset();
    run(1, 0, 4'h3, 0, 0, 0);
    do_reset();
    for (int i = 1; i <= 4; i++) run(1, 0, 4'(i), 0, 0, 0);
    run(0, 0, 0, 1, 0, 4'h5);
    do_reset();
    run(1, 0, 4'h7, 0, 0, 0);
    run(1, 0, 4'h9, 0, 0, 0);
    repeat (3) run(1, 1, 0, 0, 0, 0);
    do_reset();
    for (int i = 1; i <= 4; i++) run(0, 0, 0, 1, 0, 4'(i));
    repeat (2) run(1, 1, 0, 1, 1, 0);
    do_reset();
    run(1, 0, 4'h6, 1, 0, 4'hA);
    @(negedge clk);
    a_req = 1; a_op = 1;
    repeat (2) @(negedge clk);
    rst = 1; a_req = 0;
    @(negedge clk);
    chk("midrst_nrst", stk_nrst, 0);
    chk("midrst_count", count, 0);
    chk("midrst_ack", {a_ack, b_ack}, 0);
    rst = 0;
    ref_q.delete(); last_m = 1; rd_m = 0;
    @(negedge clk);
    chk("postrst_ack", {a_ack, b_ack, stk_pop}, 0);
    run(1, 0, 4'hC, 0, 0, 0);
    for (int i = 0; i < 60; i++) begin
      bit ra, rb;
      ra = 1'($urandom_range(0, 1));
      rb = ra ? 1'($urandom_range(0, 1)) : 1'b1;
      run(ra, 1'($urandom_range(0, 1)), 4'($urandom), rb, 1'($urandom_range(0, 1)), 4'($urandom));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
